// File: rtl/tlul_adapter_slave_q_pkg.sv
// tlul_adapter_slave_q_pkg: bus types, core-side addresses and queue entry types for the queued TL-UL slave adapter
package tlul_adapter_slave_q_pkg;
  localparam int TL_AW = 32;
  localparam int TL_DW = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam logic [TL_AW-1:0] ADAPTER_ADDRESS = 32'h0001_0000;
  localparam logic [TL_AW-1:0] STATUS_ADDRESS = 32'h0001_0008;
  localparam logic [TL_AW-1:0] MASTER_ADDRESS = 32'h0001_0010;
  typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
  typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;
  typedef struct packed {
    logic a_valid;
    tl_a_op_e a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [TL_AW-1:0] a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0] a_data;
    logic d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic d_valid;
    tl_d_op_e d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic d_sink;
    logic [TL_DW-1:0] d_data;
    tl_d_user_t d_user;
    logic d_error;
    logic a_ready;
  } tl_d2h_t;
  typedef struct packed {
    logic [TL_DW-1:0] data;
    logic [7:0] source;
    tl_a_op_e opcode;
  } req_entry_t;
  typedef struct packed {
    logic [7:0] source;
    tl_a_op_e opcode;
  } pend_entry_t;
  function automatic logic [TL_DW-1:0] bytemask(input logic [TL_DBW-1:0] be);
    for (int i = 0; i < TL_DBW; i++) bytemask[8*i+:8] = {8{be[i]}};
  endfunction
  function automatic logic [6:0] intg_fold(input logic [63:0] x);
    intg_fold = '0;
    for (int i = 0; i < 64; i++) intg_fold[i%7] ^= x[i];
  endfunction
endpackage

// File: rtl/tlul_adapter_slave_q_fifo.sv
// tlul_adapter_slave_q_fifo: synchronous FIFO with occupancy count
//   push/wdata : enqueue (caller guarantees not full)
//   pop/rdata  : dequeue, rdata shows the head (caller guarantees not empty)
//   count      : current occupancy, 0..Depth
module tlul_adapter_slave_q_fifo #(
  parameter type T = logic,
  parameter int unsigned Depth = 4,
  localparam int unsigned CW = $clog2(Depth + 1),
  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic [CW-1:0] count
);
  T mem [Depth];
  logic [PW-1:0] wptr, rptr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop) rptr <= inc(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= wdata;
  assign rdata = mem[rptr];
endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// tlul_rsp_intg_gen: appends response and data integrity to a D-channel beat
//   tl_i : raw device response
//   tl_o : same response with d_user integrity filled in
module tlul_rsp_intg_gen
  import tlul_adapter_slave_q_pkg::*;
(
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);
  always_comb begin
    tl_o = tl_i;
    tl_o.d_user.data_intg = intg_fold(64'(tl_i.d_data));
    tl_o.d_user.rsp_intg = intg_fold(64'({tl_i.d_opcode, tl_i.d_size, tl_i.d_source, tl_i.d_sink, tl_i.d_error}));
  end
endmodule

// File: rtl/tlul_adapter_slave_q.sv
// tlul_adapter_slave_q: queued TL-UL device adapter letting a core serve up to ReqDepth outstanding requests
//   clk_i, rst_ni          : clock, async active-low reset
//   req_i/gnt_o/addr_i/we_i/wdata_i/be_i : core data-bus request
//   valid_o/rdata_o/err_o  : core response, one cycle after grant
//   irq_o                  : request queue non-empty
//   tl_i/tl_o              : TL-UL device port
//   TLUL_ADAPTER_SLAVE_Q_ERR_RSP_EN : writes to MasterAddr+4 answer with d_error
module tlul_adapter_slave_q
  import tlul_adapter_slave_q_pkg::*;
#(
  parameter int unsigned ReqDepth = 4,
  parameter logic [TL_AW-1:0] AdapterAddr = ADAPTER_ADDRESS,
  parameter logic [TL_AW-1:0] MasterAddr = MASTER_ADDRESS,
  parameter logic [TL_AW-1:0] StatusAddr = STATUS_ADDRESS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [TL_AW-1:0]  addr_i,
  input  logic              we_i,
  input  logic [TL_DW-1:0]  wdata_i,
  input  logic [TL_DBW-1:0] be_i,
  output logic              valid_o,
  output logic [TL_DW-1:0]  rdata_o,
  output logic              err_o,
  output logic              irq_o,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o
);
  localparam int unsigned CW = $clog2(ReqDepth + 1);
  localparam logic [CW:0] MaxOut = (CW + 1)'(ReqDepth);
  req_entry_t req_in, req_head;
  pend_entry_t pend_in, pend_head;
  logic [CW-1:0] req_cnt, pend_cnt;
  logic a_ready, push_req, is_pop, is_stat, is_rsp, is_ersp, pop_ok, d_beat, pend_pop;
  logic unused_tl;
  tl_d2h_t tl_raw;
  // A slot stays reserved from bus acceptance until the core's answer leaves on D
  assign a_ready = ({1'b0, req_cnt} + {1'b0, pend_cnt}) < MaxOut;
  assign push_req = tl_i.a_valid & a_ready;
  assign req_in = '{data: tl_i.a_data, source: tl_i.a_source, opcode: tl_i.a_opcode};
  assign pend_in = '{source: req_head.source, opcode: req_head.opcode};
  assign is_pop = req_i & ~we_i & (addr_i == AdapterAddr);
  assign is_stat = req_i & ~we_i & (addr_i == StatusAddr);
  assign is_rsp = req_i & we_i & (addr_i == MasterAddr);
`ifdef TLUL_ADAPTER_SLAVE_Q_ERR_RSP_EN
  localparam logic [TL_AW-1:0] ErrAddr = MasterAddr + TL_AW'(4);
  assign is_ersp = req_i & we_i & (addr_i == ErrAddr);
`else
  assign is_ersp = 1'b0;
`endif
  assign pop_ok = is_pop & (req_cnt != '0);
  assign d_beat = (is_rsp | is_ersp) & (pend_cnt != '0);
  // A response write is only granted once the host takes the D beat
  assign gnt_o = req_i & (~d_beat | tl_i.d_ready);
  assign pend_pop = d_beat & tl_i.d_ready;
  assign irq_o = req_cnt != '0;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_size, tl_i.a_address, tl_i.a_mask};
  tlul_adapter_slave_q_fifo #(.T(req_entry_t), .Depth(ReqDepth)) u_req_q (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(push_req), .wdata(req_in),
    .pop(pop_ok), .rdata(req_head), .count(req_cnt)
  );
  tlul_adapter_slave_q_fifo #(.T(pend_entry_t), .Depth(ReqDepth)) u_pend_q (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(pop_ok), .wdata(pend_in),
    .pop(pend_pop), .rdata(pend_head), .count(pend_cnt)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_o <= 1'b0;
      rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      valid_o <= gnt_o;
      rdata_o <= pop_ok ? req_head.data : is_stat ? {16'h0, 8'(pend_cnt), 8'(req_cnt)} : '0;
      err_o <= gnt_o & ~(pop_ok | is_stat | d_beat);
    end
  always_comb begin
    tl_raw = '0;
    tl_raw.a_ready = a_ready;
    tl_raw.d_valid = d_beat;
    tl_raw.d_opcode = !d_beat ? AccessAck : (pend_head.opcode == Get) ? AccessAckData : AccessAck;
    tl_raw.d_size = d_beat ? 2'd2 : 2'd0;
    tl_raw.d_source = d_beat ? pend_head.source : '0;
    tl_raw.d_data = (d_beat & ~is_ersp) ? (wdata_i & bytemask(be_i)) : '0;
    tl_raw.d_error = d_beat & is_ersp;
  end
  tlul_rsp_intg_gen u_intg (.tl_i(tl_raw), .tl_o(tl_o));
endmodule
